// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg
// Shared definitions for the digit-serial adder/subtractor:
//   - FSM state encoding (IDLE / RUN)
//   - derived sizing helpers: digit count and digit-counter width
//   - parameter legality helper used for the elaboration-time check
package serial_add_sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of RUN cycles needed to consume a WIDTH-bit operand.
  function automatic int ndig_f(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit-counter width; never narrower than one bit, even when NDIG == 1.
  function automatic int cnt_w_f(input int ndig);
    return (ndig <= 32'sd1) ? 32'sd1 : $clog2(ndig);
  endfunction

  // Operand width must split evenly into digits and hold at least a sign bit
  // plus one magnitude bit.
  function automatic bit params_ok_f(input int width, input int digit);
    return (width >= 32'sd2) && (digit >= 32'sd1) && (digit <= width) &&
           ((width % digit) == 32'sd0);
  endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if
// Operand/result bundle between an operand source (master) and the
// digit-serial adder/subtractor (slave).
//   start, sub, a, b, cin : request side, driven by the master
//   busy, done, sum, cout, ovf : status/result side, driven by the slave
interface serial_add_sub_if #(
  parameter int WIDTH = 32'sd16
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_digit_add.sv
// serial_digit_add
// Combinational DIGIT-bit ripple-carry slice.
//   x, y : DIGIT-bit addends
//   ci   : carry in
//   s    : DIGIT-bit sum
//   co   : carry out of the top bit
module serial_digit_add #(
  parameter int DIGIT = 32'sd4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c_s;

  // Ripple the carry through the slice one bit at a time.
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = ci;
    for (int i = 32'sd0; i < DIGIT; i++) begin
      s[i]     = x[i] ^ y[i] ^ c_s[i];
      c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
    end
    co = c_s[DIGIT];
  end

endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock through one serial_digit_add slice, NDIG = WIDTH/DIGIT cycles per op.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : serial_add_sub_if slave (start/sub/a/b/cin in; busy/done/sum/cout/ovf out)
// Subtraction is done as a + ~b + ~cin, so cout=1 means "no borrow".
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 32'sd16,
  parameter int DIGIT = 32'sd4
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_sub_if.slave  bus
);

  localparam int NDIG  = ndig_f(WIDTH, DIGIT);
  localparam int CNT_W = cnt_w_f(NDIG);

  if (!params_ok_f(WIDTH, DIGIT)) begin : g_bad_params
    $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT, with 1 <= DIGIT <= WIDTH");
  end

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sign_a_r;
  logic             sign_b_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic [DIGIT-1:0] dsum_s;
  logic             dco_s;
  logic [WIDTH-1:0] dext_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_s;

  serial_digit_add #(.DIGIT(DIGIT)) u_slice (
    .x  (a_r[DIGIT-1:0]),
    .y  (b_r[DIGIT-1:0]),
    .ci (carry_r),
    .s  (dsum_s),
    .co (dco_s)
  );

  // New digit enters at the top of the result register; older digits move
  // down. Shift form keeps this legal when DIGIT == WIDTH.
  always_comb begin
    dext_s               = '0;
    dext_s[DIGIT-1:0]    = dsum_s;
    res_next_s           = (res_r >> DIGIT) | (dext_s << (WIDTH - DIGIT));
    last_s               = (cnt_r == CNT_W'(NDIG - 1));
  end

  // Control FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      res_r    <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sum_r    <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r      <= bus.a;
            b_r      <= bus.sub ? ~bus.b : bus.b;
            carry_r  <= bus.cin ^ bus.sub;
            cnt_r    <= '0;
            sign_a_r <= bus.a[WIDTH-1];
            sign_b_r <= bus.b[WIDTH-1] ^ bus.sub;
            res_r    <= '0;
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          carry_r <= dco_s;
          res_r   <= res_next_s;
          if (last_s) begin
            sum_r   <= res_next_s;
            cout_r  <= dco_s;
            // Overflow only possible when both addends share a sign.
            ovf_r   <= (sign_a_r == sign_b_r) && (res_next_s[WIDTH-1] != sign_a_r);
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r + 1'b1;
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub
// Drives three serial_add_sub instances (DIGIT = 4, 16, 1; WIDTH = 16) from
// one shared stimulus set and checks results, latency and handshake timing.
// Index 0 = DIGIT 4, 1 = DIGIT 16, 2 = DIGIT 1.
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_d = 1'b0;
  logic        sub_d = 1'b0;
  logic        cin_d = 1'b0;
  logic [15:0] a_d = 16'h0000;
  logic [15:0] b_d = 16'h0000;

  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(16)) if4 ();
  serial_add_sub_if #(.WIDTH(16)) if16 ();
  serial_add_sub_if #(.WIDTH(16)) if1 ();

  assign if4.start  = start_d;  assign if4.sub  = sub_d;  assign if4.cin  = cin_d;
  assign if4.a      = a_d;      assign if4.b    = b_d;
  assign if16.start = start_d;  assign if16.sub = sub_d;  assign if16.cin = cin_d;
  assign if16.a     = a_d;      assign if16.b   = b_d;
  assign if1.start  = start_d;  assign if1.sub  = sub_d;  assign if1.cin  = cin_d;
  assign if1.a      = a_d;      assign if1.b    = b_d;

  serial_add_sub #(.WIDTH(16), .DIGIT(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
  serial_add_sub #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  serial_add_sub #(.WIDTH(16), .DIGIT(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));

  logic [2:0]  busy_v, done_v, cout_v, ovf_v;
  logic [15:0] sum_v [3];
  assign busy_v = {if1.busy, if16.busy, if4.busy};
  assign done_v = {if1.done, if16.done, if4.done};
  assign cout_v = {if1.cout, if16.cout, if4.cout};
  assign ovf_v  = {if1.ovf,  if16.ovf,  if4.ovf};
  assign sum_v[0] = if4.sum;
  assign sum_v[1] = if16.sum;
  assign sum_v[2] = if1.sum;

  int ndig [3] = '{4, 1, 16};
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic        c;
    logic [15:0] es;
    logic        eco;
    logic        eov;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow from the true signed result.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic c);
    int ua, ub, sa, sb, ci, r, sr;
    logic co, ov;
    ua = 32'(a);  ub = 32'(b);
    sa = 32'($signed(a));  sb = 32'($signed(b));
    ci = 32'(c);
    if (!s) begin
      r  = ua + ub + ci;
      sr = sa + sb + ci;
      co = (r > 65535);
    end else begin
      r  = ua - ub - ci;
      sr = sa - sb - ci;
      co = (r >= 0);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, r[15:0]};
  endfunction

  task automatic wait_idle();
    int i = 0;
    while (busy_v != 3'b000 && i < 60) begin
      @(posedge clk); #1;
      i++;
    end
    check("idle_wait", 0, 32'(busy_v), 0);
  endtask

  // One operation on all DUTs; mask selects which DUTs are checked.
  // intr >= 0 pulses a junk start at that cycle offset.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic c, input logic [15:0] es, input logic eco,
                        input logic eov, input int intr, input logic [2:0] mask);
    int lat [3];
    int bc [3];
    int dc [3];
    logic [15:0] gs [3];
    logic gco [3];
    logic gov [3];
    wait_idle();
    @(negedge clk);
    a_d = a; b_d = b; sub_d = s; cin_d = c; start_d = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    a_d = 16'($urandom); b_d = 16'($urandom);
    sub_d = 1'($urandom); cin_d = 1'($urandom);
    for (int d = 0; d < 3; d++) begin
      lat[d] = -1; bc[d] = 0; dc[d] = 0; gs[d] = 16'h0; gco[d] = 1'b0; gov[d] = 1'b0;
    end
    for (int t = 0; t < 40; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      for (int d = 0; d < 3; d++) begin
        if (busy_v[d]) bc[d]++;
        if (done_v[d]) begin
          dc[d]++;
          if (lat[d] < 0) begin
            lat[d] = t; gs[d] = sum_v[d]; gco[d] = cout_v[d]; gov[d] = ovf_v[d];
          end
        end
      end
      if (t == intr) begin
        start_d = 1'b1; a_d = 16'hAAAA; b_d = 16'h5555; sub_d = 1'b1; cin_d = 1'b1;
      end else if (t == intr + 1) begin
        start_d = 1'b0;
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (mask[d]) begin
        check("sum", d, 32'(gs[d]), 32'(es));
        check("cout", d, 32'(gco[d]), 32'(eco));
        check("ovf", d, 32'(gov[d]), 32'(eov));
        check("latency", d, lat[d], ndig[d]);
        check("busy_cycles", d, bc[d], ndig[d]);
        check("done_pulses", d, dc[d], 1);
        check("sum_held", d, 32'(sum_v[d]), 32'(es));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] m;
    logic [15:0] ra, rb;
    logic rs, rc;
    int dcnt;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_busy", d, 32'(busy_v[d]), 0);
      check("rst_done", d, 32'(done_v[d]), 0);
      check("rst_sum", d, 32'(sum_v[d]), 0);
      check("rst_cout_ovf", d, 32'({cout_v[d], ovf_v[d]}), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, tbl[i].es, tbl[i].eco, tbl[i].eov,
             -1, 3'b111);
    end

    // Start while busy is ignored (DIGIT=4 instance)
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1, 3'b001);
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 2, 3'b001);

    // Back-to-back: start in the done cycle (DIGIT=4 instance)
    wait_idle();
    @(negedge clk);
    a_d = 16'h0F0F; b_d = 16'h0101; sub_d = 1'b0; cin_d = 1'b0; start_d = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    dcnt = 0;
    for (int t = 0; t < 14; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      if (done_v[0]) dcnt++;
      if (t == 4) begin
        check("b2b_done1", 0, 32'(done_v[0]), 1);
        check("b2b_sum1", 0, 32'(sum_v[0]), 32'h1010);
        check("b2b_busy_donecycle", 0, 32'(busy_v[0]), 0);
        a_d = 16'h8000; b_d = 16'h8000; sub_d = 1'b0; cin_d = 1'b0; start_d = 1'b1;
      end
      if (t == 5) begin
        start_d = 1'b0;
        check("b2b_busy2", 0, 32'(busy_v[0]), 1);
        check("b2b_done_width", 0, 32'(done_v[0]), 0);
      end
      if (t == 9) begin
        check("b2b_done2", 0, 32'(done_v[0]), 1);
        check("b2b_sum2", 0, 32'(sum_v[0]), 32'h0000);
        check("b2b_cout2", 0, 32'(cout_v[0]), 1);
        check("b2b_ovf2", 0, 32'(ovf_v[0]), 1);
      end
    end
    check("b2b_done_count", 0, dcnt, 2);

    // Randomized against the reference model
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom);  rc = 1'($urandom);
      m  = model(ra, rb, rs, rc);
      run_op(ra, rb, rs, rc, m[15:0], m[16], m[17], -1, 3'b111);
    end

    // Asynchronous reset mid-operation
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, -1, 3'b111);
    @(negedge clk);
    a_d = 16'h1234; b_d = 16'h0001; sub_d = 1'b0; cin_d = 1'b0; start_d = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", 0, 32'(busy_v[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("async_rst_busy", d, 32'(busy_v[d]), 0);
      check("async_rst_done", d, 32'(done_v[d]), 0);
      check("async_rst_sum", d, 32'(sum_v[d]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      dcnt += int'(done_v != 3'b000) + int'(busy_v != 3'b000);
    end
    check("no_done_after_rst", 0, dcnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
